// File: rtl/instruction_fetch_if.sv
// Instruction memory port of the fetch stage.
// Synchronous read: rdata is valid one cycle after addr.
interface instruction_fetch_if #(
   parameter int ADDR_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [15:0]           imem_rdata;

   modport master (
      output imem_addr,
      input  imem_rdata
   );

   modport slave (
      input  imem_addr,
      output imem_rdata
   );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads 16-bit instructions and holds them
// for the decoder until step_enable lets them retire.
module instruction_fetch #(
   parameter int ADDR_WIDTH = 8,
   parameter int RESET_PC   = 0
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  step_enable,
   input  logic                  program_counter_increment,
   input  logic                  branch_valid,
   input  logic [ADDR_WIDTH-1:0] branch_target,
   instruction_fetch_if.master   imem,
   output logic [15:0]           current_instruction,
   output logic                  instruction_valid,
   output logic                  commit,
   output logic [ADDR_WIDTH-1:0] program_counter,
   output logic [15:0]           retired_count
);

   localparam logic [ADDR_WIDTH-1:0] RST_PC = ADDR_WIDTH'(RESET_PC);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      EXEC  = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] pcr_q, pcr_d;
   logic [15:0]           instr_q, instr_d;
   logic [15:0]           retired_q, retired_d;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      pcr_d     = pcr_q;
      instr_d   = instr_q;
      retired_d = retired_q;
      unique case (state_q)
         FETCH: state_d = WAIT;
         WAIT: begin
            instr_d = imem.imem_rdata;
            pcr_d   = pc_q;
            state_d = EXEC;
         end
         EXEC: begin
            if (step_enable) begin
               state_d   = FETCH;
               retired_d = retired_q + 16'd1;
               // Branch wins over increment; neither means refetch (spin).
               if (branch_valid)
                  pc_d = branch_target;
               else if (program_counter_increment)
                  pc_d = pc_q + 1'b1;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q   <= FETCH;
         pc_q      <= RST_PC;
         pcr_q     <= RST_PC;
         instr_q   <= 16'h0000;
         retired_q <= 16'h0000;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pcr_q     <= pcr_d;
         instr_q   <= instr_d;
         retired_q <= retired_d;
      end
   end

   assign imem.imem_addr          = pc_q;
   assign current_instruction     = instr_q;
   assign program_counter         = pcr_q;
   assign retired_count           = retired_q;
   assign instruction_valid       = (state_q == EXEC);
   assign commit                  = (state_q == EXEC) && step_enable;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Upstream fetch stage for the control path: owns the program counter, reads 16-bit instructions from a synchronous instruction memory, and presents a stable `current_instruction` to the instruction decoder. It consumes the decoder's `program_counter_increment` decision and the datapath's branch redirect to choose the next PC. A step-enable input lets the front panel single-step execution.

## Interface
Parameters:
- `ADDR_WIDTH`, 8: instruction memory address width; PC width.
- `RESET_PC`, 0: PC value loaded on reset.

Ports:
- `clock`: in, 1. System clock; all state changes on the rising edge.
- `resetn`: in, 1. Reset, asynchronous and active-low.
- `step_enable`: in, 1. Permits commit of the held instruction; tie high for free-run.
- `program_counter_increment`: in, 1. From the decoder; 1 = advance PC, 0 = hold PC.
- `branch_valid`: in, 1. Redirect request from the datapath, sampled only at commit.
- `branch_target`: in, ADDR_WIDTH. Redirect address.
- `imem_addr`: out, ADDR_WIDTH. Instruction memory read address.
- `imem_rdata`: in, 16. Instruction memory data; valid one cycle after the address.
- `current_instruction`: out, 16. Instruction register; feeds the decoder.
- `instruction_valid`: out, 1. High while `current_instruction` holds a fetched instruction awaiting commit.
- `commit`: out, 1. One-cycle strobe marking the cycle the instruction retires.
- `program_counter`: out, ADDR_WIDTH. Address of `current_instruction`.
- `retired_count`: out, 16. Count of commits; wraps.

## Operation
- FSM states: FETCH, WAIT, EXEC.
- FETCH: drive `imem_addr` = PC. Go to WAIT unconditionally.
- WAIT: `imem_rdata` is valid. Latch it into `current_instruction` and latch PC into `program_counter` at the clock edge. Go to EXEC.
- EXEC: `instruction_valid` = 1. `commit` = `step_enable`.
  - If `step_enable` = 0, stay in EXEC. The instruction and `program_counter` are held, and `branch_valid` and `program_counter_increment` are ignored.
  - If `step_enable` = 1, commit the instruction and go to FETCH.
- Next-PC priority on commit:
  1. `branch_valid` = 1: PC <= `branch_target`.
  2. Otherwise, `program_counter_increment` = 1: PC <= PC + 1, modulo 2^ADDR_WIDTH. The top address wraps to 0.
  3. Otherwise: PC unchanged. The same address is refetched, which is how halt/spin is realised.
- `retired_count` increments by 1 on every commit and wraps from 16'hFFFF to 0.
- `imem_addr` always equals the PC register, so it is stable in every state.
- Reset values (asynchronous, `resetn` = 0):
  - state = FETCH
  - PC = `RESET_PC`, `program_counter` = `RESET_PC`
  - `current_instruction` = 16'h0000
  - `instruction_valid` = 0, `commit` = 0
  - `retired_count` = 0
- Reset asserted mid-instruction: all state is abandoned immediately and no commit is produced. The first fetch after release is from `RESET_PC`.

## Timing
- Minimum 3 cycles per instruction (FETCH, WAIT, EXEC).
- `commit` and `instruction_valid` are combinational decodes of the registered state and `step_enable`.
- Cycle after the `resetn` rising edge: FETCH of `RESET_PC`.
- `current_instruction` is valid from the first EXEC cycle and stays stable until the next WAIT edge. The decoder may use it throughout EXEC and FETCH.
- `program_counter_increment`, `branch_valid` and `branch_target` are sampled only on the commit edge. Their values in other cycles have no effect.
- Back-to-back commits: EXEC(commit) → FETCH of the new PC on the next cycle. There is no bubble beyond the 3-cycle cadence.
- Single-step: each 1-cycle pulse of `step_enable` during EXEC retires exactly one instruction. A `step_enable` pulse during FETCH or WAIT has no effect.

## Test plan
- Reset/free-run:
  - Stimulus: `RESET_PC` = 0, memory[0..2] = 16'h1111, 16'h2222, 16'h3333, `step_enable` = 1, increment = 1.
  - Response: `current_instruction` = 16'h1111, 16'h2222, 16'h3333 on cycles 3, 6, 9 after reset release. `commit` pulses on the same cycles. `retired_count` = 3.
- Hold:
  - Stimulus: increment = 0 at the commit of address 5.
  - Response: the next fetch is address 5 again and `program_counter` stays 5. `retired_count` still increments.
- Branch priority:
  - Stimulus: `branch_valid` = 1, `branch_target` = 8'h40, increment = 1 at commit.
  - Response: next `imem_addr` = 8'h40, not PC + 1.
- Wrap:
  - Stimulus: PC = 8'hFF, increment = 1 at commit.
  - Response: next `imem_addr` = 8'h00.
  - Stimulus: `retired_count` at 16'hFFFF, then one commit.
  - Response: `retired_count` = 0.
- Single-step:
  - Stimulus: `step_enable` = 0 for 10 cycles in EXEC, `branch_valid` toggling.
  - Response: no commit, instruction held, PC unchanged.
  - Stimulus: a 1-cycle `step_enable` pulse.
  - Response: exactly one commit and one PC update.
- Mid-operation reset:
  - Stimulus: assert `resetn` = 0 during WAIT with PC = 8'h22.
  - Response: outputs return to reset values immediately with no `commit`. After release, the fetch is from `RESET_PC`.
